// File: rtl/gemm_mmio_csr_responder_if.sv
// CCI-P c0 MMIO request / c2 MMIO response bundle between the host shim and the GEMM CSR responder.
// Handshake: requests are one-cycle valid strobes with no ready (every valid beat is taken); rsp_valid is a one-cycle strobe with no backpressure.
interface gemm_mmio_csr_responder_if;
    logic        mmio_rd_valid;
    logic        mmio_wr_valid;
    logic [15:0] mmio_addr;
    logic [1:0]  mmio_len;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wdata;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    modport master (
        output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
        input  rsp_valid, rsp_tid, rsp_data
    );

    modport slave (
        input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/gemm_mmio_csr_responder.sv
// GEMM AFU MMIO CSR block: DFH/UUID, control/status, matrix descriptors and busy-cycle counter.
// Reads answer two cycles after acceptance; writes land at the end of the accept cycle.
module gemm_mmio_csr_responder #(
    parameter int unsigned MPF_DFH_MMIO_ADDR = 32'h2000,
    parameter logic [63:0] AFU_ID_L          = 64'h0,
    parameter logic [63:0] AFU_ID_H          = 64'h0
) (
    input  logic                            clk,
    input  logic                            rst,
    gemm_mmio_csr_responder_if.slave        mmio,
    output logic                            core_start,
    input  logic                            core_done,
    output logic [63:0]                     addr_a,
    output logic [63:0]                     addr_b,
    output logic [63:0]                     addr_c,
    output logic [15:0]                     dim_m,
    output logic [15:0]                     dim_n,
    output logic [15:0]                     dim_k,
    output logic [1:0]                      state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [14:0] R_DFH     = 15'd0;
    localparam logic [14:0] R_ID_L    = 15'd1;
    localparam logic [14:0] R_ID_H    = 15'd2;
    localparam logic [14:0] R_CTRL    = 15'd5;
    localparam logic [14:0] R_STATUS  = 15'd6;
    localparam logic [14:0] R_ADDR_A  = 15'd7;
    localparam logic [14:0] R_ADDR_B  = 15'd8;
    localparam logic [14:0] R_ADDR_C  = 15'd9;
    localparam logic [14:0] R_DIMS    = 15'd10;
    localparam logic [14:0] R_CYCLE   = 15'd11;
    localparam logic [14:0] R_SCRATCH = 15'd12;
    localparam logic [63:0] DFH_VAL   = {4'h1, 20'h0, MPF_DFH_MMIO_ADDR[23:0], 16'h0};

    state_t      state_q, state_d;
    logic [63:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [63:0] scratch_q, scratch_d, cycle_cnt_q, cycle_cnt_d;
    logic [47:0] dims_q, dims_d;
    logic        core_start_q, core_start_d;
    logic        rd_v1_q, rd_v1_d;
    logic [8:0]  rd_tid1_q, rd_tid1_d;
    logic [63:0] rd_data1_q, rd_data1_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [8:0]  rsp_tid_q, rsp_tid_d;
    logic [63:0] rsp_data_q, rsp_data_d;

    logic [17:0] byte_addr;
    logic        in_window, len_ok, rd_acc, wr_acc, is_8b, hi_half;
    logic [14:0] reg_idx;
    logic [63:0] reg_val, rd_word;
    logic        start_req, clear_req;

    function automatic logic [63:0] merge_write(input logic [63:0] old_val, input logic [63:0] wdata,
                                                input logic is8, input logic hi);
        if (is8) return wdata;
        if (hi) return {wdata[31:0], old_val[31:0]};
        return {old_val[63:32], wdata[31:0]};
    endfunction

    // Anything at or above the MPF DFH belongs to MPF: no response, no side effect.
    always_comb begin
        byte_addr = {mmio.mmio_addr, 2'b00};
        in_window = 32'(byte_addr) < MPF_DFH_MMIO_ADDR;
        len_ok    = !mmio.mmio_len[1];
        rd_acc    = mmio.mmio_rd_valid && in_window && len_ok;
        wr_acc    = mmio.mmio_wr_valid && in_window && len_ok;
        is_8b     = mmio.mmio_len[0];
        hi_half   = mmio.mmio_addr[0];
        reg_idx   = mmio.mmio_addr[15:1];
    end

    always_comb begin
        reg_val = 64'h0;
        case (reg_idx)
            R_DFH:     reg_val = DFH_VAL;
            R_ID_L:    reg_val = AFU_ID_L;
            R_ID_H:    reg_val = AFU_ID_H;
            R_STATUS:  reg_val = {62'h0, state_q == ST_DONE, state_q == ST_BUSY};
            R_ADDR_A:  reg_val = addr_a_q;
            R_ADDR_B:  reg_val = addr_b_q;
            R_ADDR_C:  reg_val = addr_c_q;
            R_DIMS:    reg_val = {16'h0, dims_q};
            R_CYCLE:   reg_val = cycle_cnt_q;
            R_SCRATCH: reg_val = scratch_q;
            default:   reg_val = 64'h0;
        endcase
        if (is_8b)        rd_word = reg_val;
        else if (hi_half) rd_word = {reg_val[63:32], reg_val[63:32]};
        else              rd_word = {reg_val[31:0], reg_val[31:0]};
    end

    always_comb begin
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        addr_c_d  = addr_c_q;
        dims_d    = dims_q;
        scratch_d = scratch_q;
        start_req = 1'b0;
        clear_req = 1'b0;
        if (wr_acc) begin
            case (reg_idx)
                R_ADDR_A:  addr_a_d  = merge_write(addr_a_q, mmio.mmio_wdata, is_8b, hi_half);
                R_ADDR_B:  addr_b_d  = merge_write(addr_b_q, mmio.mmio_wdata, is_8b, hi_half);
                R_ADDR_C:  addr_c_d  = merge_write(addr_c_q, mmio.mmio_wdata, is_8b, hi_half);
                R_DIMS:    dims_d    = 48'(merge_write({16'h0, dims_q}, mmio.mmio_wdata, is_8b, hi_half));
                R_SCRATCH: scratch_d = merge_write(scratch_q, mmio.mmio_wdata, is_8b, hi_half);
                R_CTRL: begin
                    // CTRL bits live in the low dword; a 4B write to the high half carries none.
                    if (is_8b || !hi_half) begin
                        start_req = mmio.mmio_wdata[0];
                        clear_req = mmio.mmio_wdata[1];
                    end
                end
                default: ;
            endcase
        end
    end

    // core_done outranks a same-cycle start; a start while busy is dropped.
    always_comb begin
        state_d      = state_q;
        core_start_d = 1'b0;
        cycle_cnt_d  = cycle_cnt_q;
        if (state_q == ST_BUSY && cycle_cnt_q != 64'hFFFF_FFFF_FFFF_FFFF)
            cycle_cnt_d = cycle_cnt_q + 64'd1;
        if (core_done) begin
            state_d = ST_DONE;
        end else if (start_req && state_q != ST_BUSY) begin
            state_d      = ST_BUSY;
            core_start_d = 1'b1;
            cycle_cnt_d  = 64'h0;
        end else if (clear_req && state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    // Read data is captured in the accept cycle, so a same-cycle write is not visible.
    always_comb begin
        rd_v1_d     = rd_acc;
        rd_tid1_d   = rd_acc ? mmio.mmio_tid : rd_tid1_q;
        rd_data1_d  = rd_acc ? rd_word : rd_data1_q;
        rsp_valid_d = rd_v1_q;
        rsp_tid_d   = rd_v1_q ? rd_tid1_q : rsp_tid_q;
        rsp_data_d  = rd_v1_q ? rd_data1_q : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_a_q     <= 64'h0;
            addr_b_q     <= 64'h0;
            addr_c_q     <= 64'h0;
            dims_q       <= 48'h0;
            scratch_q    <= 64'h0;
            cycle_cnt_q  <= 64'h0;
            core_start_q <= 1'b0;
            rd_v1_q      <= 1'b0;
            rd_tid1_q    <= 9'h0;
            rd_data1_q   <= 64'h0;
            rsp_valid_q  <= 1'b0;
            rsp_tid_q    <= 9'h0;
            rsp_data_q   <= 64'h0;
        end else begin
            state_q      <= state_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            addr_c_q     <= addr_c_d;
            dims_q       <= dims_d;
            scratch_q    <= scratch_d;
            cycle_cnt_q  <= cycle_cnt_d;
            core_start_q <= core_start_d;
            rd_v1_q      <= rd_v1_d;
            rd_tid1_q    <= rd_tid1_d;
            rd_data1_q   <= rd_data1_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_tid_q    <= rsp_tid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign mmio.rsp_valid = rsp_valid_q;
    assign mmio.rsp_tid   = rsp_tid_q;
    assign mmio.rsp_data  = rsp_data_q;
    assign core_start     = core_start_q;
    assign addr_a         = addr_a_q;
    assign addr_b         = addr_b_q;
    assign addr_c         = addr_c_q;
    assign dim_m          = dims_q[15:0];
    assign dim_n          = dims_q[31:16];
    assign dim_k          = dims_q[47:32];
    assign state_dbg      = state_q;
endmodule
